// File: rtl/clkdiv_ctrl_if.sv
// clkdiv_ctrl_if: divide-ratio configuration handshake.
//   cfg_valid  master -> slave  new ratio offered
//   cfg_div    master -> slave  requested ratio N
//   cfg_ready  slave -> master  ratio can be accepted this cycle
//   cfg_err    slave -> master  one-cycle pulse after an illegal ratio (<2) was consumed
interface clkdiv_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable integer clock divider with glitch-free ratio changes.
//   clk        system clock
//   rst        synchronous active-low reset
//   en         run enable; dropping it finishes the current period first
//   cfg        ratio configuration handshake (slave side)
//   tick       one-cycle enable on the last cycle of each divided period
//   clk_out    registered divided clock, high for the first active_div>>1 cycles
//   active_div ratio currently in effect
//   busy       high while running (RUN or PEND)
module clkdiv_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    clkdiv_ctrl_if.slave     cfg,
    output logic             tick,
    output logic             clk_out,
    output logic [CNT_W-1:0] active_div,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] div_n;
    logic [CNT_W-1:0] pend_q, pend_n;
    logic             err_q, err_n;
    logic             clk_n;
    logic             ready, xfer, legal, at_end, running;

    assign ready         = (state_q != PEND);
    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;
    assign xfer          = cfg.cfg_valid && ready;
    assign legal         = |cfg.cfg_div[CNT_W-1:1];
    assign at_end        = (count_q == active_div - CNT_W'(1));
    assign running       = (state_q != IDLE);
    assign tick          = running && at_end;
    assign busy          = running;

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        div_n   = active_div;
        pend_n  = pend_q;
        err_n   = xfer && !legal;
        case (state_q)
            IDLE: begin
                count_n = '0;
                if (xfer && legal) div_n = cfg.cfg_div;
                if (en) state_n = RUN;
            end
            RUN: begin
                count_n = at_end ? '0 : count_q + CNT_W'(1);
                if (at_end && !en) begin
                    // Stopping at a period boundary: a ratio offered now can
                    // take effect immediately, as it would in IDLE.
                    state_n = IDLE;
                    if (xfer && legal) div_n = cfg.cfg_div;
                end else if (xfer && legal) begin
                    // Transfer on a tick cycle still waits for the next tick.
                    pend_n  = cfg.cfg_div;
                    state_n = PEND;
                end
            end
            PEND: begin
                count_n = at_end ? '0 : count_q + CNT_W'(1);
                if (at_end) begin
                    div_n   = pend_q;
                    state_n = en ? RUN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // clk_out is registered from next-cycle values so it lines up with count.
        clk_n = (state_n != IDLE) && (count_n < (div_n >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            active_div <= DEF;
            pend_q     <= DEF;
            err_q      <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            state_q    <= state_n;
            count_q    <= count_n;
            active_div <= div_n;
            pend_q     <= pend_n;
            err_q      <= err_n;
            clk_out    <= clk_n;
        end
    end
endmodule
